// File: rtl/alu_exec_unit.sv
// -----------------------------------------------------------------------------
// alu_exec_unit
//
// Single-cycle execute stage of a classic MIPS-style pipeline. Decodes the
// main-control ALU class plus the instruction funct field into a 3-bit ALU
// control, performs the ALU operation, and computes pc + 4 and the branch
// target. All outputs are registered; the result appears one cycle after the
// operands are presented with in_valid=1.
//
// Ports
//   clk            : sole clock, rising-edge
//   rst            : synchronous, active-high reset
//   in_valid       : operands/controls valid this cycle
//   alu_op [1:0]   : ALU class (00 add, 01 sub, 10 R-type via funct, 11 add)
//   funct  [5:0]   : instruction function field
//   src_a, src_b   : ALU operands
//   pc             : current instruction address
//   imm_ext        : sign-extended 16-bit immediate
//   out_valid      : registered outputs hold a valid result
//   alu_ctrl [2:0] : registered decoded ALU control
//   result         : registered ALU result
//   zero           : registered (result == 0)
//   pc_plus4       : registered pc + 4
//   branch_target  : registered pc + 4 + (imm_ext << 2)
// -----------------------------------------------------------------------------
module alu_exec_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [1:0]       alu_op,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic [WIDTH-1:0] pc,
    input  logic [WIDTH-1:0] imm_ext,
    output logic             out_valid,
    output logic [2:0]       alu_ctrl,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic [WIDTH-1:0] pc_plus4,
    output logic [WIDTH-1:0] branch_target
);

    typedef enum logic [2:0] {
        CTRL_AND = 3'b000,
        CTRL_OR  = 3'b001,
        CTRL_ADD = 3'b010,
        CTRL_SUB = 3'b110,
        CTRL_SLT = 3'b111
    } alu_ctrl_e;

    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;

    logic [2:0]       ctrl_next;
    logic [WIDTH-1:0] result_next;
    logic [WIDTH-1:0] pc_plus4_next;
    logic [WIDTH-1:0] branch_target_next;

    // ALU control decode
    always_comb begin
        // NOTE: assigning a default before the case keeps every path driven,
        // so no latch is inferred when a case arm is missing or added later.
        ctrl_next = CTRL_ADD;
        unique case (alu_op)
            2'b00: ctrl_next = CTRL_ADD;
            2'b01: ctrl_next = CTRL_SUB;
            2'b11: ctrl_next = CTRL_ADD;
            2'b10: begin
                case (funct)
                    FUNCT_ADD: ctrl_next = CTRL_ADD;
                    FUNCT_SUB: ctrl_next = CTRL_SUB;
                    FUNCT_AND: ctrl_next = CTRL_AND;
                    FUNCT_OR:  ctrl_next = CTRL_OR;
                    FUNCT_SLT: ctrl_next = CTRL_SLT;
                    default:   ctrl_next = CTRL_ADD;
                endcase
            end
            default: ctrl_next = CTRL_ADD;
        endcase
    end

    // ALU datapath; add/sub wrap naturally at WIDTH bits, carry is dropped.
    always_comb begin
        result_next = '0;
        case (ctrl_next)
            CTRL_AND: result_next = src_a & src_b;
            CTRL_OR:  result_next = src_a | src_b;
            CTRL_ADD: result_next = src_a + src_b;
            CTRL_SUB: result_next = src_a - src_b;
            CTRL_SLT: result_next = {{(WIDTH-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
            default:  result_next = '0;  // 011/100/101 are never decoded
        endcase
    end

    // Shifting in WIDTH bits drops imm_ext's top two bits, as intended.
    assign pc_plus4_next      = pc + WIDTH'(4);
    assign branch_target_next = pc_plus4_next + (imm_ext << 2);

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments here so every register samples the
        // pre-edge values, independent of statement order.
        if (rst) begin
            out_valid     <= 1'b0;
            alu_ctrl      <= '0;
            result        <= '0;
            zero          <= 1'b0;
            pc_plus4      <= '0;
            branch_target <= '0;
        end else begin
            out_valid <= in_valid;
            // Idle cycles hold the previous result so downstream can still read it.
            if (in_valid) begin
                alu_ctrl      <= ctrl_next;
                result        <= result_next;
                zero          <= (result_next == '0);
                pc_plus4      <= pc_plus4_next;
                branch_target <= branch_target_next;
            end
        end
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
// -----------------------------------------------------------------------------
// tb_alu_exec_unit
//
// Directed self-checking bench for alu_exec_unit. Each step presents one set
// of inputs before a rising edge and then compares every registered output,
// one time unit after that edge, against hand-computed values.
// -----------------------------------------------------------------------------
module tb_alu_exec_unit;

    localparam int WIDTH = 32;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic [1:0]       alu_op;
    logic [5:0]       funct;
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] imm_ext;
    logic             out_valid;
    logic [2:0]       alu_ctrl;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic [WIDTH-1:0] pc_plus4;
    logic [WIDTH-1:0] branch_target;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    alu_exec_unit #(.WIDTH(WIDTH)) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .alu_op        (alu_op),
        .funct         (funct),
        .src_a         (src_a),
        .src_b         (src_b),
        .pc            (pc),
        .imm_ext       (imm_ext),
        .out_valid     (out_valid),
        .alu_ctrl      (alu_ctrl),
        .result        (result),
        .zero          (zero),
        .pc_plus4      (pc_plus4),
        .branch_target (branch_target)
    );

    // Present one set of inputs on the falling edge, then advance just past
    // the next rising edge so the registered outputs are stable.
    task automatic step(input logic r, input logic v, input logic [1:0] op,
                        input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] p, input logic [31:0] imm);
        @(negedge clk);
        rst      = r;
        in_valid = v;
        alu_op   = op;
        funct    = f;
        src_a    = a;
        src_b    = b;
        pc       = p;
        imm_ext  = imm;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic ov, input logic [2:0] ctrl,
                         input logic [31:0] res, input logic z,
                         input logic [31:0] p4, input logic [31:0] bt);
        n_cmp++;
        assert (out_valid === ov) else begin
            n_err++;
            $error("FAIL %s.out_valid: got %b expected %b", tag, out_valid, ov);
        end
        n_cmp++;
        assert (alu_ctrl === ctrl) else begin
            n_err++;
            $error("FAIL %s.alu_ctrl: got %b expected %b", tag, alu_ctrl, ctrl);
        end
        n_cmp++;
        assert (result === res) else begin
            n_err++;
            $error("FAIL %s.result: got %h expected %h", tag, result, res);
        end
        n_cmp++;
        assert (zero === z) else begin
            n_err++;
            $error("FAIL %s.zero: got %b expected %b", tag, zero, z);
        end
        n_cmp++;
        assert (pc_plus4 === p4) else begin
            n_err++;
            $error("FAIL %s.pc_plus4: got %h expected %h", tag, pc_plus4, p4);
        end
        n_cmp++;
        assert (branch_target === bt) else begin
            n_err++;
            $error("FAIL %s.branch_target: got %h expected %h", tag, branch_target, bt);
        end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; alu_op = 2'b00; funct = 6'h00;
        src_a = '0; src_b = '0; pc = '0; imm_ext = '0;

        // Reset with a live operation: the operation must be discarded.
        step(1, 1, 2'b00, 6'h00, 32'd5, 32'd6, 32'h100, 32'h1);
        check("reset", 0, 3'b000, 32'h0, 0, 32'h0, 32'h0);

        // R-type ADD: 5+7, pc 0 -> 4, target 4 + 12 = 0x10
        step(0, 1, 2'b10, 6'b100000, 32'd5, 32'd7, 32'h0, 32'h3);
        check("radd", 1, 3'b010, 32'd12, 0, 32'h4, 32'h10);

        // beq-style SUB equal operands; negative offset: 0xC + 0xFFFFFFFC = 0x8
        step(0, 1, 2'b01, 6'h00, 32'h1234, 32'h1234, 32'h8, 32'hFFFF_FFFF);
        check("beq", 1, 3'b110, 32'h0, 1, 32'hC, 32'h8);

        step(0, 1, 2'b10, 6'b100100, 32'hF0F0, 32'h0FF0, 32'h20, 32'h0);
        check("and", 1, 3'b000, 32'h00F0, 0, 32'h24, 32'h24);

        step(0, 1, 2'b10, 6'b100101, 32'hF0F0, 32'h0FF0, 32'h24, 32'h1);
        check("or", 1, 3'b001, 32'hFFF0, 0, 32'h28, 32'h2C);

        // -1 < 1 signed
        step(0, 1, 2'b10, 6'b101010, 32'hFFFF_FFFF, 32'd1, 32'h28, 32'h0);
        check("slt_neg", 1, 3'b111, 32'h1, 0, 32'h2C, 32'h2C);

        // Most negative vs most positive
        step(0, 1, 2'b10, 6'b101010, 32'h8000_0000, 32'h7FFF_FFFF, 32'h0, 32'h0);
        check("slt_min", 1, 3'b111, 32'h1, 0, 32'h4, 32'h4);

        // Reverse ordering is not less-than
        step(0, 1, 2'b10, 6'b101010, 32'h7FFF_FFFF, 32'h8000_0000, 32'h0, 32'h0);
        check("slt_rev", 1, 3'b111, 32'h0, 1, 32'h4, 32'h4);

        step(0, 1, 2'b10, 6'b101010, 32'h55, 32'h55, 32'h0, 32'h0);
        check("slt_eq", 1, 3'b111, 32'h0, 1, 32'h4, 32'h4);

        step(0, 1, 2'b10, 6'b100010, 32'd10, 32'd3, 32'h40, 32'h2);
        check("rsub", 1, 3'b110, 32'd7, 0, 32'h44, 32'h4C);

        // Unknown funct falls back to ADD
        step(0, 1, 2'b10, 6'b000000, 32'd100, 32'd23, 32'h50, 32'h0);
        check("funct_dflt", 1, 3'b010, 32'd123, 0, 32'h54, 32'h54);

        step(0, 1, 2'b11, 6'b100010, 32'd3, 32'd4, 32'h60, 32'h0);
        check("op11_add", 1, 3'b010, 32'd7, 0, 32'h64, 32'h64);

        // Wraparound on both the ALU and pc adders
        step(0, 1, 2'b00, 6'b100100, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFC, 32'h1);
        check("wrap", 1, 3'b010, 32'h0, 1, 32'h0, 32'h4);

        // SUB underflow wraps
        step(0, 1, 2'b01, 6'h00, 32'd0, 32'd1, 32'h70, 32'h0);
        check("sub_wrap", 1, 3'b110, 32'hFFFF_FFFF, 0, 32'h74, 32'h74);

        // Idle: out_valid drops, everything else holds
        step(0, 0, 2'b10, 6'b100100, 32'h1, 32'h2, 32'h900, 32'h5);
        check("idle1", 0, 3'b110, 32'hFFFF_FFFF, 0, 32'h74, 32'h74);

        // Back-to-back with in_valid toggling
        step(0, 1, 2'b10, 6'b100101, 32'hA000_0000, 32'h0000_000A, 32'h100, 32'h4);
        check("b2b1", 1, 3'b001, 32'hA000_000A, 0, 32'h104, 32'h114);

        step(0, 1, 2'b01, 6'h00, 32'd9, 32'd9, 32'h104, 32'hFFFF_FFFE);
        check("b2b2", 1, 3'b110, 32'h0, 1, 32'h108, 32'h100);

        step(0, 0, 2'b00, 6'h00, 32'd1, 32'd1, 32'h0, 32'h0);
        check("idle2", 0, 3'b110, 32'h0, 1, 32'h108, 32'h100);

        step(0, 1, 2'b10, 6'b100000, 32'd20, 32'd22, 32'h200, 32'h10);
        check("b2b3", 1, 3'b010, 32'd42, 0, 32'h204, 32'h244);

        // Reset mid-stream with a valid operation presented
        step(1, 1, 2'b10, 6'b100101, 32'hFF, 32'hFF00, 32'h300, 32'h1);
        check("mid_rst", 0, 3'b000, 32'h0, 0, 32'h0, 32'h0);

        // First operation after reset release
        step(0, 1, 2'b00, 6'h00, 32'd1, 32'd2, 32'h10, 32'h1);
        check("post_rst", 1, 3'b010, 32'd3, 0, 32'h14, 32'h18);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
